vend_sequencer: RTL and testbench

Transaction controller for the soda vending machine. It accumulates coin credit in nickel units and gates product selection on reaching the price. It then drives the dispenser mechanism through a request/done handshake and pays out change via the coin hopper, largest coin first. It sits between the coin-acceptor/selection-button synchronisers and the dispenser and hopper actuator drivers.

---
 rtl/vend_pkg.sv | 36 +++
 rtl/change_payout.sv | 95 +++++++++
 rtl/vend_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_vend_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

    localparam int CREDIT_W = 6;

    localparam logic [CREDIT_W-1:0] NICKEL  = 6'd1;
    localparam logic [CREDIT_W-1:0] DIME    = 6'd2;
    localparam logic [CREDIT_W-1:0] QUARTER = 6'd5;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE_ISSUE,
        CHANGE_WAIT,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        PAY_IDLE,
        PAY_ISSUE,
        PAY_WAIT
    } pay_phase_t;

    // Largest coin that does not exceed the amount still owed (amount >= 1).
    function automatic logic [CREDIT_W-1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
        if (amt >= QUARTER) begin
            return QUARTER;
        end else if (amt >= DIME) begin
            return DIME;
        end else begin
            return NICKEL;
        end
    endfunction

endpackage

// File: rtl/change_payout.sv
// Greedy change engine: loads an amount on start, ejects one coin per
// issue phase, waits for the hopper ack, and times out if none arrives.
module change_payout
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [CREDIT_W-1:0] i_amount,
    input  logic                i_ack,
    output logic                o_pay_n,
    output logic                o_pay_d,
    output logic                o_pay_q,
    output logic                o_done,
    output logic                o_timeout,
    output logic [CREDIT_W-1:0] o_remaining
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    pay_phase_t          r_phase;
    pay_phase_t          w_phase_nxt;
    logic [CREDIT_W-1:0] r_remaining;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_pay_n;
    logic                r_pay_d;
    logic                r_pay_q;
    logic [CREDIT_W-1:0] w_coin;
    logic                w_last;
    logic                w_waiting;

    // The coin owed next is fixed while waiting, since remaining only moves on ack.
    assign w_coin    = greedy_coin(r_remaining);
    assign w_last    = (r_remaining == w_coin);
    assign w_waiting = (r_phase == PAY_WAIT);

    // Completion wins over timeout when both land in the same cycle.
    assign o_done      = w_waiting && i_ack && w_last;
    assign o_timeout   = w_waiting && !i_ack && (r_cnt == TO_LAST);
    assign o_pay_n     = r_pay_n;
    assign o_pay_d     = r_pay_d;
    assign o_pay_q     = r_pay_q;
    assign o_remaining = r_remaining;

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PAY_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Next-phase logic: issue one coin, then wait for its ack or a timeout.
    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            PAY_IDLE:  if (i_start) w_phase_nxt = PAY_ISSUE;
            PAY_ISSUE: w_phase_nxt = PAY_WAIT;
            PAY_WAIT: begin
                if (i_ack) begin
                    w_phase_nxt = w_last ? PAY_IDLE : PAY_ISSUE;
                end else if (o_timeout) begin
                    w_phase_nxt = PAY_IDLE;
                end
            end
            default:   w_phase_nxt = PAY_IDLE;
        endcase
    end

    // Eject pulses, amount still owed, and the ack wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
            r_cnt       <= '0;
            r_pay_n     <= 1'b0;
            r_pay_d     <= 1'b0;
            r_pay_q     <= 1'b0;
        end else begin
            r_pay_q <= (r_phase == PAY_ISSUE) && (w_coin == QUARTER);
            r_pay_d <= (r_phase == PAY_ISSUE) && (w_coin == DIME);
            r_pay_n <= (r_phase == PAY_ISSUE) && (w_coin == NICKEL);
            if ((r_phase == PAY_IDLE) && i_start) begin
                r_remaining <= i_amount;
            end else if (w_waiting && i_ack) begin
                r_remaining <= r_remaining - w_coin;
            end
            r_cnt <= w_waiting ? r_cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, selection gating,
// dispenser handshake, and change/refund through change_payout.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE_N     = 9,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                n_in,
    input  logic                d_in,
    input  logic                q_in,
    input  logic                sel_diet,
    input  logic                sel_soda,
    input  logic                cancel,
    output logic                disp_req,
    output logic                disp_item,
    input  logic                disp_done,
    output logic                pay_n,
    output logic                pay_d,
    output logic                pay_q,
    input  logic                pay_ack,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                fault
);

    localparam int                  CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]    TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_N);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W-1:0] w_add;
    logic [CREDIT_W-1:0] w_amount;
    logic [CREDIT_W-1:0] w_remaining;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                w_coin_ok;
    logic                w_reject;
    logic                w_sel;
    logic                w_start;
    logic                w_item_nxt;
    logic                w_fault_nxt;
    logic                w_pay_done;
    logic                w_pay_timeout;
    logic                r_coin_reject;
    logic                r_disp_req;
    logic                r_disp_item;
    logic                r_busy;
    logic                r_fault;

    assign w_sel       = sel_diet | sel_soda;
    assign disp_req    = r_disp_req;
    assign disp_item   = r_disp_item;
    assign coin_reject = r_coin_reject;
    assign credit      = r_credit;
    assign busy        = r_busy;
    assign fault       = r_fault;

    // Coin acceptance: only while collecting below price, priority N > D > Q.
    always_comb begin
        w_coin_ok = ((r_state == IDLE) || (r_state == COLLECT)) && (r_credit < PRICE_C);
        w_add     = '0;
        w_reject  = 1'b0;
        if (w_coin_ok) begin
            if (n_in) begin
                w_add    = NICKEL;
                w_reject = d_in | q_in;
            end else if (d_in) begin
                w_add    = DIME;
                w_reject = q_in;
            end else if (q_in) begin
                w_add    = QUARTER;
            end
        end else begin
            w_reject = n_in | d_in | q_in;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, credit and payout-start decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_start      = 1'b0;
        w_amount     = r_credit;
        w_item_nxt   = r_disp_item;
        w_fault_nxt  = r_fault;
        case (r_state)
            IDLE: begin
                if (w_add != '0) begin
                    w_state_nxt  = COLLECT;
                    w_credit_nxt = r_credit + w_add;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    // A coin accepted alongside cancel is refunded with the rest.
                    w_state_nxt  = CHANGE_ISSUE;
                    w_credit_nxt = r_credit + w_add;
                    w_amount     = r_credit + w_add;
                    w_start      = 1'b1;
                end else if ((r_credit >= PRICE_C) && w_sel) begin
                    w_state_nxt = DISPENSE;
                    w_item_nxt  = sel_diet;
                end else begin
                    w_credit_nxt = r_credit + w_add;
                end
            end
            DISPENSE: begin
                if (disp_done) begin
                    w_credit_nxt = r_credit - PRICE_C;
                    if (r_credit == PRICE_C) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = CHANGE_ISSUE;
                        w_amount    = r_credit - PRICE_C;
                        w_start     = 1'b1;
                    end
                end else if (r_wait_cnt == TO_LAST) begin
                    w_state_nxt = FAULT;
                    w_fault_nxt = 1'b1;
                end
            end
            CHANGE_ISSUE: begin
                w_state_nxt = CHANGE_WAIT;
            end
            CHANGE_WAIT: begin
                if (pay_ack) begin
                    w_credit_nxt = w_remaining - greedy_coin(w_remaining);
                    w_state_nxt  = w_pay_done ? IDLE : CHANGE_ISSUE;
                end else if (w_pay_timeout) begin
                    w_state_nxt = FAULT;
                    w_fault_nxt = 1'b1;
                end
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs and the dispenser wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit      <= '0;
            r_coin_reject <= 1'b0;
            r_disp_req    <= 1'b0;
            r_disp_item   <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_credit      <= w_credit_nxt;
            r_coin_reject <= w_reject;
            r_disp_req    <= (w_state_nxt == DISPENSE);
            r_disp_item   <= w_item_nxt;
            r_busy        <= !((w_state_nxt == IDLE) || (w_state_nxt == COLLECT));
            r_fault       <= w_fault_nxt;
            r_wait_cnt    <= (r_state == DISPENSE) ? r_wait_cnt + CNT_W'(1) : '0;
        end
    end

    change_payout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_payout (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_start),
        .i_amount   (w_amount),
        .i_ack      (pay_ack),
        .o_pay_n    (pay_n),
        .o_pay_d    (pay_d),
        .o_pay_q    (pay_q),
        .o_done     (w_pay_done),
        .o_timeout  (w_pay_timeout),
        .o_remaining(w_remaining)
    );

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer (price 9 nickels, short timeout).
module tb_vend_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       n_in = 1'b0, d_in = 1'b0, q_in = 1'b0;
    logic       sel_diet = 1'b0, sel_soda = 1'b0, cancel = 1'b0;
    logic       disp_done = 1'b0, pay_ack = 1'b0;
    logic       disp_req, disp_item, pay_n, pay_d, pay_q, coin_reject, busy, fault;
    logic [5:0] credit;

    int n_cmp = 0;
    int n_bad = 0;

    vend_sequencer #(.PRICE_N(9), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .n_in(n_in), .d_in(d_in), .q_in(q_in),
        .sel_diet(sel_diet), .sel_soda(sel_soda), .cancel(cancel),
        .disp_req(disp_req), .disp_item(disp_item), .disp_done(disp_done),
        .pay_n(pay_n), .pay_d(pay_d), .pay_q(pay_q), .pay_ack(pay_ack),
        .coin_reject(coin_reject), .credit(credit), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic n, input logic d, input logic q);
        n_in = n; d_in = d; q_in = q;
        tick();
        n_in = 1'b0; d_in = 1'b0; q_in = 1'b0;
    endtask

    task automatic pulse_sel(input logic diet, input logic soda);
        sel_diet = diet; sel_soda = soda;
        tick();
        sel_diet = 1'b0; sel_soda = 1'b0;
    endtask

    // One coin of change: pulse appears, gets acked, credit drops.
    task automatic pay_step(input string tag, input logic [2:0] exp_qdn, input int exp_credit);
        tick();
        chk({tag, "_pulse"}, {pay_q, pay_d, pay_n}, exp_qdn);
        pay_ack = 1'b1;
        tick();
        pay_ack = 1'b0;
        chk({tag, "_onecyc"}, {pay_q, pay_d, pay_n}, 3'b000);
        chk({tag, "_credit"}, credit, exp_credit);
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_disp_req", disp_req, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pays", {pay_q, pay_d, pay_n, coin_reject}, 0);

        // Exact price: Q, D, D then soda, no change
        coin(0, 0, 1); chk("t1_c5", credit, 5);
        coin(0, 1, 0); chk("t1_c7", credit, 7);
        coin(0, 1, 0); chk("t1_c9", credit, 9);
        pulse_sel(0, 1);
        chk("t1_req", disp_req, 1);
        chk("t1_item", disp_item, 0);
        chk("t1_busy", busy, 1);
        tick(); tick();
        chk("t1_req_held", disp_req, 1);
        disp_done = 1'b1; tick(); disp_done = 1'b0;
        chk("t1_req_drop", disp_req, 0);
        chk("t1_credit", credit, 0);
        chk("t1_idle", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_nopay", {pay_q, pay_d, pay_n}, 0);
        end

        // Q, Q then diet: one nickel of change
        coin(0, 0, 1); coin(0, 0, 1);
        chk("t2_c10", credit, 10);
        pulse_sel(1, 0);
        chk("t2_req", disp_req, 1);
        chk("t2_item", disp_item, 1);
        disp_done = 1'b1; tick(); disp_done = 1'b0;
        chk("t2_credit1", credit, 1);
        chk("t2_req_drop", disp_req, 0);
        chk("t2_busy", busy, 1);
        pay_step("t2_n", 3'b001, 0);
        chk("t2_idle", busy, 0);

        // Q, D then cancel: refund quarter then dime
        coin(0, 0, 1); coin(0, 1, 0);
        chk("t3_c7", credit, 7);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t3_busy", busy, 1);
        chk("t3_nopay_yet", {pay_q, pay_d, pay_n}, 0);
        pay_step("t3_q", 3'b100, 2);
        pay_step("t3_d", 3'b010, 0);
        chk("t3_idle", busy, 0);

        // Simultaneous coins, ignored selection, over-price rejection
        coin(1, 0, 1);
        chk("t4_c1", credit, 1);
        chk("t4_rej_simul", coin_reject, 1);
        coin(0, 0, 1);
        chk("t4_c6", credit, 6);
        chk("t4_rej_clear", coin_reject, 0);
        pulse_sel(0, 1);
        chk("t4_sel_ignored", disp_req, 0);
        chk("t4_c6_hold", credit, 6);
        coin(0, 0, 1);
        chk("t4_c11", credit, 11);
        coin(0, 1, 0);
        chk("t4_rej_over", coin_reject, 1);
        chk("t4_c11_hold", credit, 11);
        cancel = 1'b1; tick(); cancel = 1'b0;
        pay_step("t4_q1", 3'b100, 6);
        pay_step("t4_q2", 3'b100, 1);
        pay_step("t4_n", 3'b001, 0);

        // disp_done on the last allowed cycle: completion wins
        coin(0, 0, 1); coin(0, 0, 1);
        pulse_sel(0, 1);
        repeat (TO - 1) tick();
        chk("t5a_req_last", disp_req, 1);
        disp_done = 1'b1; tick(); disp_done = 1'b0;
        chk("t5a_fault", fault, 0);
        chk("t5a_credit", credit, 1);
        pay_step("t5a_n", 3'b001, 0);

        // Dispenser timeout
        coin(0, 0, 1); coin(0, 0, 1);
        pulse_sel(1, 0);
        repeat (TO - 1) tick();
        chk("t5_req_last", disp_req, 1);
        chk("t5_nofault_yet", fault, 0);
        tick();
        chk("t5_fault", fault, 1);
        chk("t5_req_drop", disp_req, 0);
        chk("t5_busy", busy, 1);
        coin(0, 1, 0);
        chk("t5_rej", coin_reject, 1);
        chk("t5_credit_frozen", credit, 10);
        disp_done = 1'b1; tick(); disp_done = 1'b0;
        chk("t5_done_ignored", credit, 10);
        chk("t5_fault_sticky", fault, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_rst_fault", fault, 0);
        chk("t5_rst_credit", credit, 0);
        chk("t5_rst_busy", busy, 0);

        // Reset while waiting for the hopper
        coin(0, 0, 1); coin(0, 1, 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        tick();
        chk("t6_pay_q", pay_q, 1);
        reset = 1'b1; tick();
        chk("t6_credit", credit, 0);
        chk("t6_busy", busy, 0);
        chk("t6_pays", {pay_q, pay_d, pay_n}, 0);
        chk("t6_misc", {disp_req, fault, coin_reject}, 0);
        reset = 1'b0;
        pay_ack = 1'b1; tick(); pay_ack = 1'b0;
        chk("t6_ack_ignored", credit, 0);
        chk("t6_idle", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_nopay", {pay_q, pay_d, pay_n}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
